// File: rtl/corr_sched.sv
// corr_sched
// Sequencer for a shared, time-multiplexed autocorrelation engine. One frame
// of 2*MAX_TAU samples is captured into an external dual-read sample RAM.
// A single external MAC is then swept over every lag in [MIN_TAU, MAX_TAU).
// The largest correlation is tracked, and its lag is published as the period
// estimate.
//
// Ports
//   clk, rst          : clock and synchronous active-high reset
//   start             : one-cycle run request, honoured only when idle
//   sample_valid      : one strobe per incoming sample
//   wr_en, wr_addr    : sample RAM write port
//   rd_en             : RAM read / MAC product enable
//   rd_addr_a         : sample index i
//   rd_addr_b         : sample index i+tau
//   mac_clr           : zero the accumulator
//   mac_last          : final product of the current lag
//   acc_in            : accumulator value returned by the MAC
//   busy              : high whenever not idle
//   done              : one-cycle pulse when peak_tau/peak_val are published
//   peak_tau          : lag of the maximum correlation
//   peak_val          : correlation value at peak_tau
//
// Build option
//   CORR_SCHED_CONT_EN : when defined, the block restarts capture right after
//                        every result and free-runs until reset.

module corr_sched #(
   parameter int MAX_TAU = 256,
   parameter int MIN_TAU = 50,
   parameter int MAC_LAT = 2,
   parameter int ACC_W   = 32,
   localparam int AW     = $clog2(2*MAX_TAU)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    sample_valid,
   output logic                    wr_en,
   output logic [AW-1:0]           wr_addr,
   output logic                    rd_en,
   output logic [AW-1:0]           rd_addr_a,
   output logic [AW-1:0]           rd_addr_b,
   output logic                    mac_clr,
   output logic                    mac_last,
   input  logic signed [ACC_W-1:0] acc_in,
   output logic                    busy,
   output logic                    done,
   output logic [15:0]             peak_tau,
   output logic signed [ACC_W-1:0] peak_val
);

   localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

   localparam logic [AW-1:0] LAST_ADDR  = AW'(2*MAX_TAU-1);
   localparam logic [AW-1:0] LAST_I     = AW'(MAX_TAU-1);
   localparam logic [AW-1:0] LAST_TAU   = AW'(MAX_TAU-1);
   localparam logic [AW-1:0] FIRST_TAU  = AW'(MIN_TAU);
   localparam logic [DW-1:0] LAST_DRAIN = DW'(MAC_LAT-1);
   localparam logic signed [ACC_W-1:0] MOST_NEG = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_CAPTURE,
      S_CLEAR,
      S_ACCUM,
      S_DRAIN,
      S_COMPARE,
      S_DONE
   } state_t;

   state_t state, state_n;

   // Internal bookkeeping registers and their next values
   logic [AW-1:0]           wr_cnt, wr_cnt_n;
   logic [AW-1:0]           i_cnt, i_cnt_n;
   logic [AW-1:0]           tau, tau_n;
   logic [DW-1:0]           drain_cnt, drain_cnt_n;
   logic signed [ACC_W-1:0] best_val, best_val_n;
   logic [AW-1:0]           best_tau, best_tau_n;

   // Next values of the registered outputs
   logic                    wr_en_n, rd_en_n, mac_clr_n, mac_last_n;
   logic                    busy_n, done_n;
   logic [AW-1:0]           wr_addr_n, rd_addr_a_n, rd_addr_b_n;
   logic [15:0]             peak_tau_n;
   logic signed [ACC_W-1:0] peak_val_n;

   // Scratch values for the lag step and the peak comparison
   logic [AW-1:0]           i_next;
   logic                    better;
   logic signed [ACC_W-1:0] cmp_val;
   logic [AW-1:0]           cmp_tau;

   // State and output registers. Every output comes straight from a flop, so
   // the combinational block below computes what the outputs must show in
   // the cycle that the next state is entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         wr_cnt    <= '0;
         i_cnt     <= '0;
         tau       <= '0;
         drain_cnt <= '0;
         best_val  <= '0;
         best_tau  <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         rd_en     <= 1'b0;
         rd_addr_a <= '0;
         rd_addr_b <= '0;
         mac_clr   <= 1'b0;
         mac_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         peak_tau  <= '0;
         peak_val  <= '0;
      end else begin
         state     <= state_n;
         wr_cnt    <= wr_cnt_n;
         i_cnt     <= i_cnt_n;
         tau       <= tau_n;
         drain_cnt <= drain_cnt_n;
         best_val  <= best_val_n;
         best_tau  <= best_tau_n;
         wr_en     <= wr_en_n;
         wr_addr   <= wr_addr_n;
         rd_en     <= rd_en_n;
         rd_addr_a <= rd_addr_a_n;
         rd_addr_b <= rd_addr_b_n;
         mac_clr   <= mac_clr_n;
         mac_last  <= mac_last_n;
         busy      <= busy_n;
         done      <= done_n;
         peak_tau  <= peak_tau_n;
         peak_val  <= peak_val_n;
      end
   end

   // The peak comparison made in COMPARE. It is strict, so on a tie the
   // earlier (lower) lag is kept.
   always_comb begin
      better  = (acc_in > best_val);
      cmp_val = better ? acc_in : best_val;
      cmp_tau = better ? tau : best_tau;
      i_next  = i_cnt + AW'(1);
   end

   // Next-state and next-output logic. Strobes default low, and addresses
   // and results hold their values. Each state only overrides what changes
   // when it moves on.
   always_comb begin
      state_n     = state;
      wr_cnt_n    = wr_cnt;
      i_cnt_n     = i_cnt;
      tau_n       = tau;
      drain_cnt_n = drain_cnt;
      best_val_n  = best_val;
      best_tau_n  = best_tau;
      wr_en_n     = 1'b0;
      wr_addr_n   = wr_addr;
      rd_en_n     = 1'b0;
      rd_addr_a_n = rd_addr_a;
      rd_addr_b_n = rd_addr_b;
      mac_clr_n   = 1'b0;
      mac_last_n  = 1'b0;
      busy_n      = 1'b1;
      done_n      = 1'b0;
      peak_tau_n  = peak_tau;
      peak_val_n  = peak_val;

      case (state)
         S_IDLE: begin
            busy_n = 1'b0;
            if (start) begin
               state_n   = S_CAPTURE;
               busy_n    = 1'b1;
               wr_addr_n = '0;
               wr_cnt_n  = '0;
            end
         end

         // The write to the last address is still shown in CAPTURE. The move
         // to CLEAR happens once that write strobe is on the outputs.
         S_CAPTURE: begin
            if (wr_en && (wr_addr == LAST_ADDR)) begin
               state_n    = S_CLEAR;
               mac_clr_n  = 1'b1;
               tau_n      = FIRST_TAU;
               best_val_n = MOST_NEG;
               best_tau_n = FIRST_TAU;
            end else if (sample_valid) begin
               wr_en_n   = 1'b1;
               wr_addr_n = wr_cnt;
               wr_cnt_n  = wr_cnt + AW'(1);
            end
         end

         S_CLEAR: begin
            state_n     = S_ACCUM;
            i_cnt_n     = '0;
            rd_en_n     = 1'b1;
            rd_addr_a_n = '0;
            rd_addr_b_n = tau;
         end

         // The product for i_cnt is on the outputs now. Issue i_cnt+1, or
         // stop after the product flagged with mac_last.
         S_ACCUM: begin
            if (i_cnt == LAST_I) begin
               state_n     = S_DRAIN;
               drain_cnt_n = '0;
            end else begin
               i_cnt_n     = i_next;
               rd_en_n     = 1'b1;
               rd_addr_a_n = i_next;
               rd_addr_b_n = i_next + tau;
               mac_last_n  = (i_next == LAST_I);
            end
         end

         S_DRAIN: begin
            if (drain_cnt == LAST_DRAIN) begin
               state_n = S_COMPARE;
            end else begin
               drain_cnt_n = drain_cnt + DW'(1);
            end
         end

         // The result is published in the same cycle that DONE is entered.
         // The published values therefore include this last comparison.
         S_COMPARE: begin
            best_val_n = cmp_val;
            best_tau_n = cmp_tau;
            if (tau == LAST_TAU) begin
               state_n    = S_DONE;
               done_n     = 1'b1;
               peak_tau_n = 16'(cmp_tau);
               peak_val_n = cmp_val;
            end else begin
               state_n   = S_CLEAR;
               tau_n     = tau + AW'(1);
               mac_clr_n = 1'b1;
            end
         end

         S_DONE: begin
`ifdef CORR_SCHED_CONT_EN
            state_n   = S_CAPTURE;
            wr_addr_n = '0;
            wr_cnt_n  = '0;
`else
            state_n = S_IDLE;
            busy_n  = 1'b0;
`endif
         end

         default: begin
            state_n = S_IDLE;
            busy_n  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_corr_sched.sv
// Testbench for corr_sched with MAX_TAU=16, MIN_TAU=2, MAC_LAT=2.
// It provides an ideal sample RAM and a MAC with a latency of two cycles.
// Expected peaks come either from a constant table or from a reference model
// that correlates the frame directly.

module tb_corr_sched;

   localparam int MAX_TAU = 16;
   localparam int MIN_TAU = 2;
   localparam int MAC_LAT = 2;
   localparam int ACC_W   = 32;
   localparam int AW      = 5;
   localparam int FRAME   = 2*MAX_TAU;
   localparam int LATENCY = (MAX_TAU-MIN_TAU)*(MAX_TAU+MAC_LAT+2) + 2;

   localparam int K_SQUARE = 0;
   localparam int K_CONST  = 1;
   localparam int K_RANDOM = 2;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    start;
   logic                    sample_valid;
   logic                    wr_en;
   logic [AW-1:0]           wr_addr;
   logic                    rd_en;
   logic [AW-1:0]           rd_addr_a;
   logic [AW-1:0]           rd_addr_b;
   logic                    mac_clr;
   logic                    mac_last;
   logic signed [ACC_W-1:0] acc_in;
   logic                    busy;
   logic                    done;
   logic [15:0]             peak_tau;
   logic signed [ACC_W-1:0] peak_val;

   always #5 clk = ~clk;

   corr_sched #(
      .MAX_TAU (MAX_TAU),
      .MIN_TAU (MIN_TAU),
      .MAC_LAT (MAC_LAT),
      .ACC_W   (ACC_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .sample_valid (sample_valid),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .rd_en        (rd_en),
      .rd_addr_a    (rd_addr_a),
      .rd_addr_b    (rd_addr_b),
      .mac_clr      (mac_clr),
      .mac_last     (mac_last),
      .acc_in       (acc_in),
      .busy         (busy),
      .done         (done),
      .peak_tau     (peak_tau),
      .peak_val     (peak_val)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Frame that the bench intends to deliver, and the RAM the DUT writes it into
   int                      frame [FRAME];
   logic signed [ACC_W-1:0] ram   [FRAME];

   // Ideal MAC: a registered sum followed by one delay stage, giving MAC_LAT=2
   logic signed [ACC_W-1:0] mac_sum;
   logic signed [ACC_W-1:0] acc_pipe;
   assign acc_in = acc_pipe;

   always @(posedge clk) begin
      cyc = cyc + 1;
   end

   always @(posedge clk) begin
      if (wr_en) ram[wr_addr] <= ACC_W'(frame[wr_addr]);
      if (mac_clr) mac_sum <= '0;
      else if (rd_en) mac_sum <= mac_sum + ram[rd_addr_a] * ram[rd_addr_b];
      acc_pipe <= mac_sum;
   end

   // Monitors sample between edges. They count writes, check write order,
   // track the largest read address and catch peak outputs that move
   // without a done pulse.
   int          wr_count   = 0;
   int          wr_order_e = 0;
   int          max_rd_b   = 0;
   int          done_count = 0;
   int          peak_err   = 0;
   logic [15:0] prev_tau;
   logic signed [ACC_W-1:0] prev_val;

   always @(negedge clk) begin
      if (wr_en) begin
         if (int'(wr_addr) != wr_count) wr_order_e++;
         wr_count++;
      end
      if (rd_en && int'(rd_addr_b) > max_rd_b) max_rd_b = int'(rd_addr_b);
      if (done) done_count++;
      if (cyc > 2 && !done && (peak_tau != prev_tau || peak_val != prev_val)
          && !(peak_tau == 16'd0 && peak_val == '0))
         peak_err++;
      prev_tau = peak_tau;
      prev_val = peak_val;
   end

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic fillFrame(input int kind, input int amp, input int period);
      for (int i = 0; i < FRAME; i++) begin
         case (kind)
            K_SQUARE: frame[i] = ((i % period) < (period / 2)) ? amp : -amp;
            K_CONST:  frame[i] = amp;
            default:  frame[i] = int'($urandom_range(4000, 0)) - 2000;
         endcase
      end
   endtask

   // Correlation sums for every searched lag. The first strictly greater
   // sum wins, so a tie is resolved in favour of the lower lag.
   task automatic refModel(output int best_tau, output longint best_val);
      best_tau = MIN_TAU;
      best_val = 0;
      for (int t = MIN_TAU; t < MAX_TAU; t++) begin
         longint s = 0;
         for (int i = 0; i < MAX_TAU; i++) s += longint'(frame[i]) * longint'(frame[i+t]);
         if (t == MIN_TAU || s > best_val) begin
            best_val = s;
            best_tau = t;
         end
      end
   endtask

   // Optionally pulse start (with a same-cycle sample_valid that must be
   // dropped), then deliver FRAME strobes separated by 'gap' idle cycles.
   // The task ends at the cycle after the last strobe.
   task automatic applyStimulus(input int gap, input bit with_start, output int last_sv);
      last_sv = 0;
      if (with_start) begin
         start        = 1'b1;
         sample_valid = 1'b1;
         @(posedge clk); #1;
         start        = 1'b0;
         sample_valid = 1'b0;
         checkOutput("busy after start", longint'(busy), 1);
      end
      for (int k = 0; k < FRAME; k++) begin
         repeat (gap) begin @(posedge clk); #1; end
         sample_valid = 1'b1;
         last_sv      = cyc;
         @(posedge clk); #1;
         sample_valid = 1'b0;
      end
   endtask

   task automatic waitDone(output int done_cyc);
      done_cyc = -1;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (done) begin
            done_cyc = cyc;
            break;
         end
      end
      checkOutput("done timeout", longint'(done_cyc >= 0), 1);
      @(posedge clk); #1;
   endtask

   task automatic runAndCheck(input string tag, input int gap, input int exp_tau, input longint exp_val);
      int last_sv, done_cyc;
      wr_count   = 0;
      wr_order_e = 0;
      max_rd_b   = 0;
      applyStimulus(gap, 1'b1, last_sv);
      waitDone(done_cyc);
      checkOutput({tag, " write count"}, wr_count, FRAME);
      checkOutput({tag, " write order"}, wr_order_e, 0);
      checkOutput({tag, " max rd_addr_b"}, max_rd_b, 2*MAX_TAU-2);
      checkOutput({tag, " latency"}, done_cyc - last_sv, LATENCY);
      checkOutput({tag, " peak_tau"}, longint'(peak_tau), exp_tau);
      checkOutput({tag, " peak_val"}, longint'(peak_val), exp_val);
      checkOutput({tag, " idle after done"}, longint'(busy), 0);
   endtask

   typedef struct {
      int     kind;
      int     amp;
      int     period;
      int     gap;
      int     exp_tau;
      longint exp_val;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int     last_sv, done_cyc, d0, rtau, found;
      longint rval;

      vecs[0] = '{K_SQUARE, 1000, 8, 19, 8, 64'd16000000};
      vecs[1] = '{K_CONST,   100, 0,  2, 2, 64'd160000};
      vecs[2] = '{K_SQUARE, 1000, 4,  1, 4, 64'd16000000};
      vecs[3] = '{K_SQUARE,  500, 2,  1, 2, 64'd4000000};
      vecs[4] = '{K_SQUARE, 1000, 6,  2, 6, 64'd16000000};
      vecs[5] = '{K_CONST,  -300, 0,  1, 2, 64'd1440000};

      rst          = 1'b1;
      start        = 1'b0;
      sample_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("reset busy", longint'(busy), 0);
      checkOutput("reset done", longint'(done), 0);
      checkOutput("reset wr_en", longint'(wr_en), 0);
      checkOutput("reset rd_en", longint'(rd_en), 0);
      checkOutput("reset mac_clr", longint'(mac_clr), 0);
      checkOutput("reset mac_last", longint'(mac_last), 0);
      checkOutput("reset wr_addr", longint'(wr_addr), 0);
      checkOutput("reset rd_addr_a", longint'(rd_addr_a), 0);
      checkOutput("reset rd_addr_b", longint'(rd_addr_b), 0);
      checkOutput("reset peak_tau", longint'(peak_tau), 0);
      checkOutput("reset peak_val", longint'(peak_val), 0);

      // Strobes without start must never reach the RAM
      @(posedge clk); #1;
      wr_count = 0;
      for (int k = 0; k < 5; k++) begin
         sample_valid = 1'b1;
         @(posedge clk); #1;
         sample_valid = 1'b0;
         @(posedge clk); #1;
      end
      checkOutput("idle sample_valid writes", wr_count, 0);
      checkOutput("idle busy", longint'(busy), 0);

`ifdef CORR_SCHED_CONT_EN
      // Free-running: one start, then two frames and two results
      fillFrame(K_SQUARE, 1000, 8);
      d0 = done_count;
      applyStimulus(2, 1'b1, last_sv);
      waitDone(done_cyc);
      checkOutput("cont first peak_tau", longint'(peak_tau), 8);
      checkOutput("cont busy after done", longint'(busy), 1);
      checkOutput("cont done pulse width", longint'(done), 0);
      fillFrame(K_CONST, 100, 0);
      wr_count = 0;
      applyStimulus(2, 1'b0, last_sv);
      waitDone(done_cyc);
      checkOutput("cont second write count", wr_count, FRAME);
      checkOutput("cont second latency", done_cyc - last_sv, LATENCY);
      checkOutput("cont second peak_tau", longint'(peak_tau), 2);
      checkOutput("cont second peak_val", longint'(peak_val), 160000);
      checkOutput("cont done count", done_count - d0, 2);
`else
      // Table of frames with known periods and tie cases
      for (int v = 0; v < 6; v++) begin
         fillFrame(vecs[v].kind, vecs[v].amp, vecs[v].period);
         runAndCheck($sformatf("vec%0d", v), vecs[v].gap, vecs[v].exp_tau, vecs[v].exp_val);
      end

      // Random frames against the reference model
      for (int r = 0; r < 4; r++) begin
         fillFrame(K_RANDOM, 0, 0);
         refModel(rtau, rval);
         runAndCheck($sformatf("rand%0d", r), 1, rtau, rval);
      end

      // A start that arrives mid-search is neither restarted nor queued
      fillFrame(K_SQUARE, 1000, 8);
      applyStimulus(1, 1'b1, last_sv);
      found = 0;
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         if (rd_en) begin found = 1; break; end
      end
      checkOutput("accum reached", found, 1);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      waitDone(done_cyc);
      checkOutput("start-in-accum peak_tau", longint'(peak_tau), 8);
      d0 = done_count;
      repeat (400) @(posedge clk);
      #1;
      checkOutput("no second done", done_count - d0, 0);
      checkOutput("idle after ignored start", longint'(busy), 0);

      // Reset during DRAIN discards the run and clears the published peak
      fillFrame(K_RANDOM, 0, 0);
      applyStimulus(1, 1'b1, last_sv);
      found = 0;
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         if (mac_last) begin found = 1; break; end
      end
      checkOutput("mac_last reached", found, 1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      checkOutput("drain reset busy", longint'(busy), 0);
      checkOutput("drain reset peak_tau", longint'(peak_tau), 0);
      checkOutput("drain reset peak_val", longint'(peak_val), 0);
      checkOutput("drain reset rd_en", longint'(rd_en), 0);
      fillFrame(K_SQUARE, 1000, 8);
      runAndCheck("after reset", 2, 8, 64'd16000000);
`endif

      checkOutput("peak outputs stable between done", peak_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/corr_sched.md
# corr_sched

Sequencer for a shared, time-multiplexed autocorrelation engine. It captures one frame of DC-removed ADC samples into a dual-read sample RAM, then runs a single external MAC over every lag in [MIN_TAU, MAX_TAU). It tracks the correlation peak and reports the lag of the maximum as the period estimate. It sits between the DC-removal stage (source of `sample_valid`) and the period/stability logic (consumer of `peak_tau`), replacing the fully parallel per-lag datapath.

## Interface
- `MAX_TAU`, default 256: lag count; frame length is 2*MAX_TAU; power of two.
- `MIN_TAU`, default 50: first lag searched; 1 ≤ MIN_TAU < MAX_TAU.
- `MAC_LAT`, default 2: cycles from the `mac_last` cycle until `acc_in` holds the final sum; ≥1.
- `ACC_W`, default 32: MAC accumulator width.
- `AW`: derived, $clog2(2*MAX_TAU).

Ports:
- `clk` in, 1: system clock, 200 MHz.
- `rst` in, 1: synchronous, active-high reset.
- `start` in, 1: one-cycle request to run capture and search; ignored unless IDLE.
- `sample_valid` in, 1: one-cycle strobe per new sample, already synchronised to `clk`.
- `wr_en` out, 1: RAM write strobe, equal to `sample_valid` during CAPTURE.
- `wr_addr` out, AW: RAM write address.
- `rd_en` out, 1: RAM read / MAC product enable.
- `rd_addr_a` out, AW: sample index i.
- `rd_addr_b` out, AW: sample index i+tau.
- `mac_clr` out, 1: zero the accumulator.
- `mac_last` out, 1: marks the final `rd_en` of the current lag.
- `acc_in` in, ACC_W signed: accumulator value from the MAC.
- `busy` out, 1: high in every state except IDLE.
- `done` out, 1: one-cycle pulse when a result is published.
- `peak_tau` out, 16: lag of the maximum correlation.
- `peak_val` out, ACC_W signed: correlation value at `peak_tau`.

## Operation
States: IDLE, CAPTURE, CLEAR, ACCUM, DRAIN, COMPARE, DONE.
- **IDLE**: all strobes low. `start` → CAPTURE with `wr_addr`=0.
- **CAPTURE**
  - Each `sample_valid` asserts `wr_en` at the current `wr_addr` and then increments it.
  - After the write at address 2*MAX_TAU-1: go to CLEAR with tau=MIN_TAU, best_val = most-negative ACC_W value, best_tau = MIN_TAU.
  - No wrap: every run is a fresh frame.
- **CLEAR**: `mac_clr`=1 for one cycle, i=0 → ACCUM.
- **ACCUM**
  - `rd_en`=1 every cycle, `rd_addr_a`=i, `rd_addr_b`=i+tau, for i = 0…MAX_TAU-1.
  - Max `rd_addr_b` is 2*MAX_TAU-2, so addresses never overflow.
  - `mac_last`=1 when i=MAX_TAU-1 → DRAIN.
- **DRAIN**: wait MAC_LAT cycles with all strobes low → COMPARE.
- **COMPARE**
  - Sample `acc_in`. If acc_in > best_val (signed, strict), update best_val and best_tau.
  - Ties keep the lower lag.
  - If tau = MAX_TAU-1 → DONE; else tau+1 → CLEAR.
- **DONE**: load `peak_tau`/`peak_val` from best_*, pulse `done` → IDLE.
- `sample_valid` outside CAPTURE is dropped; no counting, no side effects.
- `start` while busy is ignored (not queued).

## Timing
- Reset values: `busy`, `done`, `wr_en`, `rd_en`, `mac_clr`, `mac_last` = 0; `wr_addr`, `rd_addr_a`, `rd_addr_b` = 0; `peak_tau` = 0; `peak_val` = 0.
- All outputs are registered. Strobes assert in the cycle the state is entered.
- `start` at cycle t → `busy`=1 at t+1.
- Per-lag cost is 1 + MAX_TAU + MAC_LAT + 1 cycles.
- Search latency, from the last capture write to `done`: (MAX_TAU-MIN_TAU)·(MAX_TAU+MAC_LAT+2) + 2 cycles.
  - Defaults: 206·260 + 2 = 53 562 cycles ≈ 268 µs.
- `peak_tau`/`peak_val` change only in the `done` cycle and hold until the next `done` or `rst`.
- `rst` mid-operation: next cycle is IDLE with reset values. Partial results are discarded and `peak_*` returns to 0.
- `sample_valid` in the same cycle as `start`: ignored, because capture begins the following cycle.

## Configuration
- `CORR_SCHED_CONT_EN` defined:
  - DONE goes straight to CAPTURE (`wr_addr`=0); `busy` stays high.
  - The block free-runs after the first `start`. Only `rst` stops it.
- Undefined: DONE → IDLE and each run needs a `start` pulse.

## Test plan
Bench parameters: MAX_TAU=16, MIN_TAU=2, MAC_LAT=2, ideal MAC model.
- **Reset**: `rst` high for 3 cycles → all outputs 0, `busy`=0. `sample_valid` strobes without `start` → `wr_en` stays 0.
- **Capture**: `start`, then 32 `sample_valid` strobes at 1-in-20 spacing → `wr_addr` runs 0…31. CLEAR follows the 32nd write; `rd_addr_b` never exceeds 30.
- **Period detect**:
  - Stimulus: square wave of period 8 (±1000).
  - Expect `peak_tau`=8, `done` exactly 14·20+2 = 282 cycles after the last write.
  - Expect `peak_val` = 16·10⁶.
- **Tie**: constant +100 samples (all lags equal) → `peak_tau`=2, i.e. the lowest lag wins.
- **Mid-run reset and start**:
  - `start` during ACCUM is ignored, and no second `done` follows.
  - `rst` during DRAIN → IDLE next cycle, `peak_tau`=0. A fresh run then completes normally.
- **Continuous mode**: with `CORR_SCHED_CONT_EN` → after `done`, the next cycle is CAPTURE, and two consecutive `done` pulses occur without a second `start`.
